// File: rtl/tlb_pkg.sv
// Shared widths, PTE field positions and walker state encoding for the TLB refill path.
package tlb_pkg;

  localparam int VPN_W   = 34;
  localparam int PFN_W   = 26;
  localparam int PA_W    = PFN_W + 12;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int LVL_IDX_W = 17;

  localparam int PTE_V       = 0;
  localparam int PTE_L       = 1;
  localparam int PTE_PFN_MSB = 35;
  localparam int PTE_PFN_LSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_L1_REQ  = 3'd1,
    ST_L1_WAIT = 3'd2,
    ST_L2_REQ  = 3'd3,
    ST_L2_WAIT = 3'd4,
    ST_REFILL  = 3'd5,
    ST_FAULT   = 3'd6
  } walk_state_e;

  // Table base plus 8-byte PTE offset; the sum deliberately wraps at PA_W bits.
  function automatic logic [PA_W-1:0] pte_addr(input logic [PFN_W-1:0] base,
                                               input logic [LVL_IDX_W-1:0] idx);
    return {base, 12'b0} + {{(PA_W-LVL_IDX_W-3){1'b0}}, idx, 3'b000};
  endfunction

endpackage

// File: rtl/tlb_victim_ptr.sv
// Round-robin victim selector for the TLB CAM; advances only when a refill is written.
module tlb_victim_ptr
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [IDX_W-1:0] ptr_o
);

  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + IDX_W'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker: turns a TLB miss into either a CAM refill write or a fault strobe.
module tlb_refill_walker
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PFN_W-1:0] ptbr_pfn,
  input  logic             miss_valid,
  input  logic [VPN_W-1:0] miss_vpn,
  output logic             miss_ready,
  output logic             mem_req_valid,
  output logic [PA_W-1:0]  mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_data,
  output logic             refill_valid,
  output logic [IDX_W-1:0] refill_index,
  output logic [VPN_W-1:0] refill_vpn,
  output logic [PFN_W-1:0] refill_pfn,
  output logic             fault_valid,
  output logic [VPN_W-1:0] fault_vpn,
  output logic             fault_level
);

  walk_state_e      state_q, state_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [PFN_W-1:0] ptbr_q, ptbr_d;
  logic [PFN_W-1:0] pfn_q, pfn_d;
  logic             faultLevel_q, faultLevel_d;
  logic [IDX_W-1:0] victimPtr;

  logic             pteV, pteL;
  logic [PFN_W-1:0] ptePfn;
  logic             unusedPteBits;

  assign pteV          = mem_resp_data[PTE_V];
  assign pteL          = mem_resp_data[PTE_L];
  assign ptePfn        = mem_resp_data[PTE_PFN_MSB:PTE_PFN_LSB];
  assign unusedPteBits = ^{mem_resp_data[63:PTE_PFN_MSB+1], mem_resp_data[PTE_PFN_LSB-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vpn_q        <= '0;
      ptbr_q       <= '0;
      pfn_q        <= '0;
      faultLevel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      ptbr_q       <= ptbr_d;
      pfn_q        <= pfn_d;
      faultLevel_q <= faultLevel_d;
    end
  end

  // pfn_q holds the L2 table base during the second level, then the leaf PFN for the refill.
  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    ptbr_d       = ptbr_q;
    pfn_d        = pfn_q;
    faultLevel_d = faultLevel_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          vpn_d   = miss_vpn;
          ptbr_d  = ptbr_pfn;
          state_d = ST_L1_REQ;
        end
      end
      ST_L1_REQ:  if (mem_req_ready) state_d = ST_L1_WAIT;
      ST_L1_WAIT: begin
        if (mem_resp_valid) begin
          if (!pteV || pteL) begin
            faultLevel_d = 1'b0;
            state_d      = ST_FAULT;
          end else begin
            pfn_d   = ptePfn;
            state_d = ST_L2_REQ;
          end
        end
      end
      ST_L2_REQ:  if (mem_req_ready) state_d = ST_L2_WAIT;
      ST_L2_WAIT: begin
        if (mem_resp_valid) begin
          if (!pteV || !pteL) begin
            faultLevel_d = 1'b1;
            state_d      = ST_FAULT;
          end else begin
            pfn_d   = ptePfn;
            state_d = ST_REFILL;
          end
        end
      end
      ST_REFILL: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req_addr = '0;
    case (state_q)
      ST_L1_REQ: mem_req_addr = pte_addr(ptbr_q, vpn_q[33:17]);
      ST_L2_REQ: mem_req_addr = pte_addr(pfn_q, vpn_q[16:0]);
      default:   mem_req_addr = '0;
    endcase
  end

  assign miss_ready    = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_L1_REQ) || (state_q == ST_L2_REQ);

  // Data outputs are forced to zero whenever their strobe is low.
  assign refill_valid = (state_q == ST_REFILL);
  assign refill_index = refill_valid ? victimPtr : '0;
  assign refill_vpn   = refill_valid ? vpn_q : '0;
  assign refill_pfn   = refill_valid ? pfn_q : '0;
  assign fault_valid  = (state_q == ST_FAULT);
  assign fault_vpn    = fault_valid ? vpn_q : '0;
  assign fault_level  = fault_valid & faultLevel_q;

  tlb_victim_ptr u_victim_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (refill_valid),
    .ptr_o (victimPtr)
  );

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: directed spec scenarios plus randomized walks against a PTE-rule model.
module tb_tlb_refill_walker;

  logic        clk;
  logic        rst_n;
  logic [25:0] ptbr_pfn;
  logic        miss_valid;
  logic [33:0] miss_vpn;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [37:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        refill_valid;
  logic [5:0]  refill_index;
  logic [33:0] refill_vpn;
  logic [25:0] refill_pfn;
  logic        fault_valid;
  logic [33:0] fault_vpn;
  logic        fault_level;

  int testsRun = 0;
  int failCount = 0;
  int modelVictim = 0;

  int          obsRefills, obsFaults, strobeCycle, readyCycle, reqCount;
  bit          timedOut, addrUnstable, busyReady;
  logic [37:0] obsAddr [2];
  logic [5:0]  obsIndex;
  logic [33:0] obsVpn, obsFaultVpn;
  logic [25:0] obsPfn;
  logic        obsLevel;

  bit          expFault, expLevel;
  logic [25:0] expPfn;
  logic [37:0] expAddr1, expAddr2;
  int          expReqs, expStrobeCycle;

  tlb_refill_walker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ptbr_pfn       (ptbr_pfn),
    .miss_valid     (miss_valid),
    .miss_vpn       (miss_vpn),
    .miss_ready     (miss_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .refill_valid   (refill_valid),
    .refill_index   (refill_index),
    .refill_vpn     (refill_vpn),
    .refill_pfn     (refill_pfn),
    .fault_valid    (fault_valid),
    .fault_vpn      (fault_vpn),
    .fault_level    (fault_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected outcome from the PTE rules, using plain 64-bit arithmetic and a 2^38 modulus.
  function automatic void model_walk(input logic [25:0] ptbr, input logic [33:0] vpn,
                                     input logic [63:0] p1, input logic [63:0] p2, input int stall);
    longint unsigned modulus, idx1, idx0, base, pfn1, pfn2;
    modulus = 64'd1 << 38;
    idx1 = 64'(vpn) / (64'd1 << 17);
    idx0 = 64'(vpn) % (64'd1 << 17);
    base = 64'(ptbr) * 4096;
    pfn1 = (p1 / 1024) % (64'd1 << 26);
    pfn2 = (p2 / 1024) % (64'd1 << 26);
    expAddr1 = 38'((base + idx1 * 8) % modulus);
    expAddr2 = '0;
    expPfn   = '0;
    expLevel = 1'b0;
    if ((p1 % 2) == 0 || ((p1 / 2) % 2) == 1) begin
      expFault = 1'b1;
      expReqs = 1;
      expStrobeCycle = 3 + stall;
    end else begin
      expAddr2 = 38'((pfn1 * 4096 + idx0 * 8) % modulus);
      expReqs = 2;
      expStrobeCycle = 5 + 2 * stall;
      if ((p2 % 2) == 0 || ((p2 / 2) % 2) == 0) begin
        expFault = 1'b1;
        expLevel = 1'b1;
      end else begin
        expFault = 1'b0;
        expPfn = 26'(pfn2);
      end
    end
  endfunction

  // Acts as requester and memory for one walk; records what the walker did, cycle 0 = acceptance.
  task automatic run_walk(input logic [25:0] ptbr, input logic [33:0] vpn, input logic [63:0] p1,
                          input logic [63:0] p2, input int stall, input bit stray, input int abortCycle);
    int stallCnt;
    bit respNext, respDue, strobeSeen;
    logic [63:0] respData;
    obsRefills = 0; obsFaults = 0; strobeCycle = -1; readyCycle = -1; reqCount = 0;
    timedOut = 0; addrUnstable = 0; busyReady = 0;
    obsAddr[0] = '0; obsAddr[1] = '0;
    stallCnt = 0; respNext = 0; strobeSeen = 0; respData = '0;
    for (int i = 0; i < 50 && !miss_ready; i++) @(negedge clk);
    if (!miss_ready) begin
      timedOut = 1;
      return;
    end
    miss_valid = 1'b1; miss_vpn = vpn; ptbr_pfn = ptbr;
    @(posedge clk);
    #1;
    miss_valid = 1'b0; miss_vpn = 34'({$urandom, $urandom}); ptbr_pfn = 26'($urandom);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == abortCycle) begin
        rst_n = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        return;
      end
      respDue = respNext;
      respNext = 0;
      mem_resp_valid = respDue;
      mem_resp_data = respDue ? respData : 64'({$urandom, $urandom});
      if (!respDue && stray && mem_req_valid) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = {$urandom, $urandom} | 64'h3;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid && reqCount < 2) begin
        if (stallCnt == 0) obsAddr[reqCount] = mem_req_addr;
        else if (mem_req_addr !== obsAddr[reqCount]) addrUnstable = 1;
        if (stallCnt < stall) begin
          stallCnt++;
        end else begin
          mem_req_ready = 1'b1;
          respNext = 1;
          respData = (reqCount == 0) ? p1 : p2;
          reqCount++;
          stallCnt = 0;
        end
      end
      if (miss_ready && !strobeSeen) busyReady = 1;
      if (refill_valid) begin
        obsRefills++; obsIndex = refill_index; obsVpn = refill_vpn; obsPfn = refill_pfn;
        strobeCycle = cyc; strobeSeen = 1;
      end
      if (fault_valid) begin
        obsFaults++; obsFaultVpn = fault_vpn; obsLevel = fault_level;
        strobeCycle = cyc; strobeSeen = 1;
      end
      if (strobeSeen && cyc > strobeCycle && miss_ready) begin
        readyCycle = cyc;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        return;
      end
    end
    timedOut = 1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_valid = 1'b0; miss_vpn = '0; ptbr_pfn = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    #2;
    testsRun++;
    if (miss_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_miss_ready: got %b expected 1", miss_ready); end
    testsRun++;
    if ({mem_req_valid, refill_valid, fault_valid} !== 3'b000) begin
      failCount++; $display("[TB] FAIL reset_strobes: got %b expected 000", {mem_req_valid, refill_valid, fault_valid});
    end
    testsRun++;
    if ({mem_req_addr, refill_index, refill_vpn, refill_pfn, fault_vpn, fault_level} !== '0) begin
      failCount++; $display("[TB] FAIL reset_data: got %h expected 0",
                            {mem_req_addr, refill_index, refill_vpn, refill_pfn, fault_vpn, fault_level});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    modelVictim = 0;
    @(negedge clk);
  endtask

  task automatic test_l1_fault();
    run_walk(26'h100, 34'h20003, 64'h0, 64'hEAF3403, 0, 0, 0);
    testsRun++;
    if (timedOut || obsFaults !== 1 || obsRefills !== 0) begin
      failCount++; $display("[TB] FAIL l1_fault_strobes: got faults=%0d refills=%0d timeout=%0d expected 1/0/0", obsFaults, obsRefills, timedOut);
    end
    testsRun++;
    if (obsLevel !== 1'b0 || obsFaultVpn !== 34'h20003) begin
      failCount++; $display("[TB] FAIL l1_fault_info: got level=%b vpn=%h expected 0/20003", obsLevel, obsFaultVpn);
    end
    testsRun++;
    if (strobeCycle !== 3 || reqCount !== 1) begin
      failCount++; $display("[TB] FAIL l1_fault_timing: got cycle=%0d reqs=%0d expected 3/1", strobeCycle, reqCount);
    end
  endtask

  task automatic test_walk_directed();
    run_walk(26'h100, 34'h20003, 64'h80001, 64'hEAF3403, 0, 0, 0);
    testsRun++;
    if (obsAddr[0] !== 38'h100008 || obsAddr[1] !== 38'h200018) begin
      failCount++; $display("[TB] FAIL walk_addrs: got %h %h expected 100008 200018", obsAddr[0], obsAddr[1]);
    end
    testsRun++;
    if (timedOut || obsRefills !== 1 || obsFaults !== 0) begin
      failCount++; $display("[TB] FAIL walk_strobes: got refills=%0d faults=%0d timeout=%0d expected 1/0/0", obsRefills, obsFaults, timedOut);
    end
    testsRun++;
    if (obsPfn !== 26'h3ABCD || obsVpn !== 34'h20003 || obsIndex !== 6'd0) begin
      failCount++; $display("[TB] FAIL walk_refill_data: got pfn=%h vpn=%h idx=%0d expected 3abcd/20003/0", obsPfn, obsVpn, obsIndex);
    end
    testsRun++;
    if (strobeCycle !== 5 || readyCycle !== 6 || busyReady) begin
      failCount++; $display("[TB] FAIL walk_timing: got refill=%0d ready=%0d busyReady=%0d expected 5/6/0", strobeCycle, readyCycle, busyReady);
    end
    modelVictim = 1;
  endtask

  task automatic test_l2_fault();
    run_walk(26'h100, 34'h20003, 64'h80001, 64'h80001, 0, 0, 0);
    testsRun++;
    if (timedOut || obsFaults !== 1 || obsRefills !== 0) begin
      failCount++; $display("[TB] FAIL l2_fault_strobes: got faults=%0d refills=%0d expected 1/0", obsFaults, obsRefills);
    end
    testsRun++;
    if (obsLevel !== 1'b1 || strobeCycle !== 5) begin
      failCount++; $display("[TB] FAIL l2_fault_info: got level=%b cycle=%0d expected 1/5", obsLevel, strobeCycle);
    end
  endtask

  task automatic test_backpressure();
    run_walk(26'h100, 34'h20003, 64'h80001, 64'hEAF3403, 5, 1, 0);
    testsRun++;
    if (addrUnstable || obsAddr[0] !== 38'h100008 || obsAddr[1] !== 38'h200018) begin
      failCount++; $display("[TB] FAIL bp_addr: got unstable=%0d %h %h expected 0 100008 200018", addrUnstable, obsAddr[0], obsAddr[1]);
    end
    testsRun++;
    if (timedOut || strobeCycle !== 15 || obsRefills !== 1) begin
      failCount++; $display("[TB] FAIL bp_timing: got cycle=%0d refills=%0d expected 15/1", strobeCycle, obsRefills);
    end
    testsRun++;
    if (obsIndex !== 6'(modelVictim) || obsPfn !== 26'h3ABCD) begin
      failCount++; $display("[TB] FAIL bp_refill: got idx=%0d pfn=%h expected %0d/3abcd", obsIndex, obsPfn, modelVictim);
    end
    modelVictim = (modelVictim + 1) % 64;
  endtask

  task automatic test_random_walks(input int n);
    logic [63:0] p1, p2;
    logic [25:0] ptbr;
    logic [33:0] vpn;
    int stall;
    for (int w = 0; w < n; w++) begin
      ptbr = 26'($urandom); vpn = 34'({$urandom, $urandom});
      p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: p1[0] = 1'b0;
        1: p1[1:0] = 2'b11;
        default: p1[1:0] = 2'b01;
      endcase
      case ($urandom_range(0, 5))
        0: p2[0] = 1'b0;
        1: p2[1:0] = 2'b01;
        default: p2[1:0] = 2'b11;
      endcase
      stall = $urandom_range(0, 3);
      model_walk(ptbr, vpn, p1, p2, stall);
      run_walk(ptbr, vpn, p1, p2, stall, 1, 0);
      testsRun++;
      if (timedOut || reqCount !== expReqs || obsAddr[0] !== expAddr1 || obsAddr[1] !== expAddr2 || addrUnstable) begin
        failCount++; $display("[TB] FAIL rand_req[%0d]: got reqs=%0d a1=%h a2=%h expected %0d %h %h", w, reqCount, obsAddr[0], obsAddr[1], expReqs, expAddr1, expAddr2);
      end
      testsRun++;
      if (strobeCycle !== expStrobeCycle || readyCycle !== expStrobeCycle + 1 || busyReady) begin
        failCount++; $display("[TB] FAIL rand_timing[%0d]: got strobe=%0d ready=%0d expected %0d/%0d", w, strobeCycle, readyCycle, expStrobeCycle, expStrobeCycle + 1);
      end
      testsRun++;
      if (expFault) begin
        if (obsFaults !== 1 || obsRefills !== 0 || obsLevel !== expLevel || obsFaultVpn !== vpn) begin
          failCount++; $display("[TB] FAIL rand_fault[%0d]: got f=%0d r=%0d lvl=%b vpn=%h expected 1/0/%b/%h", w, obsFaults, obsRefills, obsLevel, obsFaultVpn, expLevel, vpn);
        end
      end else begin
        if (obsRefills !== 1 || obsFaults !== 0 || obsPfn !== expPfn || obsVpn !== vpn || obsIndex !== 6'(modelVictim)) begin
          failCount++; $display("[TB] FAIL rand_refill[%0d]: got r=%0d pfn=%h vpn=%h idx=%0d expected 1/%h/%h/%0d", w, obsRefills, obsPfn, obsVpn, obsIndex, expPfn, vpn, modelVictim);
        end
        modelVictim = (modelVictim + 1) % 64;
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    bit sawStrobe, sawBusy;
    run_walk(26'h100, 34'h20003, 64'h80001, 64'hEAF3403, 0, 0, 4);
    #1;
    testsRun++;
    if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0 || refill_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL midreset_state: got ready=%b req=%b refill=%b expected 1/0/0", miss_ready, mem_req_valid, refill_valid);
    end
    modelVictim = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 64'hEAF3403;
    sawStrobe = 0; sawBusy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (refill_valid || fault_valid) sawStrobe = 1;
      if (!miss_ready || mem_req_valid) sawBusy = 1;
    end
    testsRun++;
    if (sawStrobe || sawBusy) begin
      failCount++; $display("[TB] FAIL midreset_late_resp: got strobe=%0d busy=%0d expected 0/0", sawStrobe, sawBusy);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] p1, p2;
    int badIdx;
    badIdx = 0;
    for (int w = 0; w < 65; w++) begin
      p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
      p1[1:0] = 2'b01; p2[1:0] = 2'b11;
      run_walk(26'($urandom), 34'({$urandom, $urandom}), p1, p2, 0, 0, 0);
      testsRun++;
      if (timedOut || obsRefills !== 1 || obsIndex !== 6'(w % 64)) begin
        failCount++; badIdx++;
        $display("[TB] FAIL wrap_index[%0d]: got idx=%0d refills=%0d expected %0d/1", w, obsIndex, obsRefills, w % 64);
      end
    end
    modelVictim = 1;
  endtask

  initial begin
    test_reset();
    test_l1_fault();
    test_walk_directed();
    test_l2_fault();
    test_backpressure();
    test_random_walks(30);
    test_reset_mid_walk();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/tlb_refill_walker.md
# tlb_refill_walker

Two-level hardware page-table walker that services misses from the 64-entry TLB CAM (34-bit VPN, 26-bit PFN). It accepts a missing VPN, reads two 64-bit PTEs from memory, and either emits a one-cycle refill write (VPN, PFN, victim index) into the CAM or reports a fault. It sits directly downstream of the CAM miss path and upstream of the CAM entry-write port.

## Interface
- `VPN_W`, 34, virtual page number width
- `PFN_W`, 26, physical frame number width
- `PA_W`, 38, physical address width (`PFN_W`+12)
- `ENTRIES`, 64, TLB entries; victim index width is log2(`ENTRIES`)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ptbr_pfn` in 26: root page-table PFN, sampled at miss acceptance
- `miss_valid` in 1: miss request
- `miss_vpn` in 34: missing VPN
- `miss_ready` out 1: walker idle, can accept a miss
- `mem_req_valid` out 1: PTE read request
- `mem_req_addr` out 38: byte address of the PTE
- `mem_req_ready` in 1: memory accepts the request
- `mem_resp_valid` in 1: read data valid (no backpressure)
- `mem_resp_data` in 64: PTE
- `refill_valid` out 1: one-cycle CAM write strobe
- `refill_index` out 6: victim entry
- `refill_vpn` out 34: VPN to write
- `refill_pfn` out 26: PFN to write
- `fault_valid` out 1: one-cycle fault strobe
- `fault_vpn` out 34: faulting VPN
- `fault_level` out 1: 0 = first-level PTE, 1 = second-level PTE

## Operation
- PTE format: bit0 V (valid), bit1 L (leaf), bits[35:10] PFN; other bits ignored.
- VPN split: `idx1` = vpn[33:17], `idx0` = vpn[16:0].
- L1 address = {ptbr_pfn, 12'b0} + {idx1, 3'b0}.
- L2 address = {L1.PFN, 12'b0} + {idx0, 3'b0}.
- Both additions are `PA_W`-bit and wrap modulo 2^38.
- FSM states: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, REFILL, FAULT.
- IDLE: `miss_ready`=1. When `miss_valid`, latch VPN and ptbr, then go to L1_REQ.
- Lx_REQ: `mem_req_valid`=1 with a stable address. On `mem_req_ready`, go to Lx_WAIT.
- L1_WAIT, on response:
  - V=0 or L=1: FAULT with level 0.
  - Otherwise: latch PFN and go to L2_REQ.
- L2_WAIT, on response:
  - V=0 or L=0: FAULT with level 1.
  - Otherwise: latch PFN and go to REFILL.
- REFILL: `refill_valid`=1 for exactly one cycle. The victim pointer then increments (63 wraps to 0). Next state is IDLE.
- FAULT: `fault_valid`=1 for exactly one cycle. The victim pointer is unchanged. Next state is IDLE.
- `mem_resp_valid` outside the WAIT states is ignored.
- One walk in flight at a time. `miss_ready` is 0 in every state except IDLE.

## Timing
- Reset values:
  - state = IDLE, so `miss_ready`=1
  - victim pointer = 0
  - all other outputs 0: `mem_req_valid`, `refill_valid`, `fault_valid`, and the data outputs
- Handshake timing with zero-wait memory (`mem_req_ready`=1, response one cycle after handshake):
  - cycle 0: miss accepted
  - cycle 1: L1 request
  - cycle 2: L1 response
  - cycle 3: L2 request
  - cycle 4: L2 response
  - cycle 5: `refill_valid`
  - cycle 6: `miss_ready`=1 again
- Earliest fault is at cycle 3.
- Request stall: `mem_req_valid` and `mem_req_addr` are held until `mem_req_ready`.
- Refill and fault data outputs are registered and valid only while their strobe is high.
- Reset mid-walk: return immediately to IDLE. No strobe is issued. A later `mem_resp_valid` is ignored.

## Structure
- Shared package `tlb_pkg` holds:
  - widths `VPN_W`, `PFN_W`, `PA_W`
  - PTE bit positions (V=0, L=1, PFN msb=35, lsb=10)
  - the walker state enum
- One natural sub-module: `tlb_victim_ptr`, a 6-bit round-robin counter with an increment enable.

## Test plan
- Successful walk:
  - Stimulus: ptbr=26'h100, vpn=34'h20003. L1 PTE 64'h80001 is returned at address 38'h100008. L2 PTE 64'hEAF3403 is returned at address 38'h200018.
  - Response: `refill_pfn`=26'h3ABCD, `refill_vpn`=34'h20003, `refill_index`=0 at cycle 5.
- L1 invalid: L1 PTE 64'h0.
  - Response: `fault_valid`, `fault_level`=0, no refill, victim pointer remains 0.
- L2 non-leaf: L2 PTE 64'h80001.
  - Response: `fault_valid`, `fault_level`=1.
- Backpressure: `mem_req_ready` held low for 5 cycles on each request.
  - Response: address is stable throughout; refill occurs at cycle 15.
- Wrap: 65 successful walks.
  - Response: `refill_index` runs 0..63, then 0.
- Reset mid-walk: `rst_n` asserted low in L2_WAIT, then a late response arrives.
  - Response: IDLE, no strobe, `miss_ready`=1 after reset release.
